// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the execute stage.
// Each operand is resolved against the producer stages behind execute, then
// against a short history of writes that retired while execute was held.

// Per-operand resolver: picks the highest-priority producer of one register.
module fwd_operand #(
    parameter int NUM_STAGES = 3,
    parameter int XLEN       = 32,
    parameter int HIST_DEPTH = 2,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic [4:0]                             idx,
    input  logic [XLEN-1:0]                        rf,
    input  logic [NUM_STAGES-1:0]                  stg_wen,
    input  logic [NUM_STAGES-1:0]                  stg_ready,
    input  logic [NUM_STAGES-1:0][4:0]             stg_rd,
    input  logic [NUM_STAGES-1:0][XLEN-1:0]        stg_data,
    input  logic [HIST_DEPTH-1:0]                  hist_vld,
    input  logic [HIST_DEPTH-1:0][4:0]             hist_rd,
    input  logic [HIST_DEPTH-1:0][XLEN-1:0]        hist_data,
    output logic [XLEN-1:0]                        res,
    output logic                                   stall_req
);
    // Priority scan: youngest stage first, then newest history entry.
    // The first hit decides; a non-ready young stage blocks older ready ones.
    always_comb begin
        logic found;
        res       = rf;
        stall_req = 1'b0;
        found     = 1'b0;
        if (idx != 5'd0) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (!found && stg_wen[i] && stg_rd[i] == idx) begin
                    found = 1'b1;
                    if (FWD_EN && stg_ready[i]) res = stg_data[i];
                    else                        stall_req = 1'b1;
                end
            end
            for (int j = 0; j < HIST_DEPTH; j++) begin
                if (!found && hist_vld[j] && hist_rd[j] == idx) begin
                    found = 1'b1;
                    res   = hist_data[j];
                end
            end
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int XLEN       = 32,
    parameter int HIST_DEPTH = 2,
    parameter bit FWD_EN     = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       exe_valid,
    input  logic                       exe_advance,
    input  logic [NUM_SRC*5-1:0]       src_idx,
    input  logic [NUM_SRC-1:0]         src_use,
    input  logic [NUM_SRC*XLEN-1:0]    src_rf,
    input  logic [NUM_STAGES-1:0]      stg_wen,
    input  logic [NUM_STAGES*5-1:0]    stg_rd,
    input  logic [NUM_STAGES-1:0]      stg_ready,
    input  logic [NUM_STAGES*XLEN-1:0] stg_data,
    input  logic                       stg_shift,
    output logic [NUM_SRC*XLEN-1:0]    src_out,
    output logic                       hazard_stall,
    output logic                       hist_ovf,
    output logic [CNT_W-1:0]           stall_cnt
);
    localparam int OLD = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0][4:0]      stg_rd_a;
    logic [NUM_STAGES-1:0][XLEN-1:0] stg_data_a;
    logic [NUM_SRC-1:0][4:0]         src_idx_a;
    logic [NUM_SRC-1:0][XLEN-1:0]    src_rf_a;
    logic [NUM_SRC-1:0][XLEN-1:0]    src_out_a;
    logic [NUM_SRC-1:0]              stall_req;

    // History entry 0 is the newest retired write.
    logic [HIST_DEPTH-1:0]           hist_vld;
    logic [HIST_DEPTH-1:0][4:0]      hist_rd;
    logic [HIST_DEPTH-1:0][XLEN-1:0] hist_data;

    logic retire;

    assign stg_rd_a   = stg_rd;
    assign stg_data_a = stg_data;
    assign src_idx_a  = src_idx;
    assign src_rf_a   = src_rf;
    assign src_out    = src_out_a;

    genvar k;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_op
            fwd_operand #(
                .NUM_STAGES (NUM_STAGES),
                .XLEN       (XLEN),
                .HIST_DEPTH (HIST_DEPTH),
                .FWD_EN     (FWD_EN)
            ) u_op (
                .idx       (src_idx_a[k]),
                .rf        (src_rf_a[k]),
                .stg_wen   (stg_wen),
                .stg_ready (stg_ready),
                .stg_rd    (stg_rd_a),
                .stg_data  (stg_data_a),
                .hist_vld  (hist_vld),
                .hist_rd   (hist_rd),
                .hist_data (hist_data),
                .res       (src_out_a[k]),
                .stall_req (stall_req[k])
            );
        end
    endgenerate

    // Unused operands resolve but never hold execute.
    assign hazard_stall = exe_valid & (|(stall_req & src_use));

    // The oldest stage writes the regfile now; x0 writes are not worth keeping.
    assign retire = stg_shift & stg_wen[OLD] & (stg_rd_a[OLD] != 5'd0);

    // History: cleared whenever execute moves on or is empty, otherwise
    // captures retirements so the held instruction does not lose them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_vld <= '0;
            hist_ovf <= 1'b0;
        end else if (exe_advance || !exe_valid) begin
            hist_vld <= '0;
        end else if (retire) begin
            if (&hist_vld) hist_ovf <= 1'b1;
            for (int j = HIST_DEPTH - 1; j > 0; j--) begin
                hist_vld[j]  <= hist_vld[j-1];
                hist_rd[j]   <= hist_rd[j-1];
                hist_data[j] <= hist_data[j-1];
            end
            hist_vld[0]  <= 1'b1;
            hist_rd[0]   <= stg_rd_a[OLD];
            hist_data[0] <= stg_data_a[OLD];
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (hazard_stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a forwarding instance (default parameters) and a
// stall-only instance with a 4-bit counter share the same stimulus.
module tb_fwd_hazard_unit;
    localparam int NS = 2, NT = 3, XL = 32, HD = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic exe_valid, exe_advance, stg_shift;
    logic [NS-1:0][4:0]    src_idx;
    logic [NS-1:0]         src_use;
    logic [NS-1:0][XL-1:0] src_rf;
    logic [NT-1:0]         stg_wen, stg_ready;
    logic [NT-1:0][4:0]    stg_rd;
    logic [NT-1:0][XL-1:0] stg_data;

    logic [NS*XL-1:0] out_a, out_b;
    logic             stall_a, stall_b, ovf_a, ovf_b;
    logic [15:0]      cnt_a;
    logic [3:0]       cnt_b;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(NS), .NUM_STAGES(NT), .XLEN(XL), .HIST_DEPTH(HD),
                      .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .exe_advance(exe_advance),
        .src_idx(src_idx), .src_use(src_use), .src_rf(src_rf),
        .stg_wen(stg_wen), .stg_rd(stg_rd), .stg_ready(stg_ready), .stg_data(stg_data),
        .stg_shift(stg_shift), .src_out(out_a), .hazard_stall(stall_a),
        .hist_ovf(ovf_a), .stall_cnt(cnt_a));

    fwd_hazard_unit #(.NUM_SRC(NS), .NUM_STAGES(NT), .XLEN(XL), .HIST_DEPTH(HD),
                      .FWD_EN(1'b0), .CNT_W(4)) u_stl (
        .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .exe_advance(exe_advance),
        .src_idx(src_idx), .src_use(src_use), .src_rf(src_rf),
        .stg_wen(stg_wen), .stg_rd(stg_rd), .stg_ready(stg_ready), .stg_data(stg_data),
        .stg_shift(stg_shift), .src_out(out_b), .hazard_stall(stall_b),
        .hist_ovf(ovf_b), .stall_cnt(cnt_b));

    // scoreboard: selector picks which DUT output an entry is compared against
    localparam int S_OUT0 = 0, S_OUT1 = 1, S_STALL = 2, S_OVF = 3, S_CNT = 4,
                   S_STALL_B = 5, S_CNT_B = 6;
    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_(input string tag, input int sel, input logic [31:0] exp);
        tag_q.push_back(tag); sel_q.push_back(sel); exp_q.push_back(exp);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_OUT0:    return out_a[31:0];
            S_OUT1:    return out_a[63:32];
            S_STALL:   return {31'd0, stall_a};
            S_OVF:     return {31'd0, ovf_a};
            S_CNT:     return {16'd0, cnt_a};
            S_STALL_B: return {31'd0, stall_b};
            S_CNT_B:   return {28'd0, cnt_b};
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    // compare everything queued for this cycle at the falling edge, then
    // let the rising edge happen and re-drive shortly after it
    task automatic step();
        @(negedge clk);
        while (sel_q.size() > 0)
            chk(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_valid = 1'b1; exe_advance = 1'b0; stg_shift = 1'b0;
        src_idx = '0; src_use = '1; src_rf = '0;
        stg_wen = '0; stg_rd = '0; stg_ready = '0; stg_data = '0;
    endtask

    task automatic stg(input int i, input logic [4:0] rd, input logic rdy, input logic [31:0] d);
        stg_wen[i] = 1'b1; stg_rd[i] = rd; stg_ready[i] = rdy; stg_data[i] = d;
    endtask

    task automatic src(input int k, input logic [4:0] idx, input logic u, input logic [31:0] rf);
        src_idx[k] = idx; src_use[k] = u; src_rf[k] = rf;
    endtask

    task automatic do_reset();
        idle(); rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        #1;
        do_reset();
        expect_("rst_ovf", S_OVF, 0);
        expect_("rst_cnt", S_CNT, 0);
        expect_("rst_cnt_b", S_CNT_B, 0);
        expect_("rst_stall", S_STALL, 0);
        step();

        // stage-0 ALU forward; x0 operand passes its regfile value
        idle(); src(0, 5, 1, 32'h55); src(1, 0, 1, 32'h99); stg(0, 5, 1, 32'h1234);
        expect_("s0_fwd", S_OUT0, 32'h1234);
        expect_("s0_x0", S_OUT1, 32'h99);
        expect_("s0_stall", S_STALL, 0);
        expect_("s0_stall_b", S_STALL_B, 1);
        step();
        idle();
        expect_("s0_cnt", S_CNT, 0);
        step();

        // load-use: young non-ready load hides an older ready producer
        idle(); src(1, 7, 1, 32'h77); stg(0, 7, 0, 0); stg(1, 7, 1, 32'hAA);
        expect_("lu_stall", S_STALL, 1);
        expect_("lu_out", S_OUT1, 32'h77);
        step();
        src_use[1] = 1'b0;
        expect_("lu_unused", S_STALL, 0);
        expect_("lu_cnt", S_CNT, 1);
        step();
        src_use[1] = 1'b1; exe_valid = 1'b0;
        expect_("lu_noexe", S_STALL, 0);
        step();

        // x0 against stages writing r0, then stage priority
        idle(); src(0, 0, 1, 32'h1111);
        stg(0, 0, 1, 32'hF0); stg(1, 0, 1, 32'hF1); stg(2, 0, 1, 32'hF2);
        expect_("x0_out", S_OUT0, 32'h1111);
        expect_("x0_stall", S_STALL, 0);
        step();
        idle(); src(0, 3, 1, 32'h3); stg(0, 3, 1, 32'h11); stg(2, 3, 1, 32'h22);
        expect_("prio_out", S_OUT0, 32'h11);
        step();
        idle(); src(1, 4, 1, 32'h4); stg(0, 4, 0, 0); stg(2, 4, 1, 32'h44);
        expect_("young_nr_stall", S_STALL, 1);
        expect_("young_nr_out", S_OUT1, 32'h4);
        step();
        idle();
        expect_("prio_cnt", S_CNT, 2);
        step();

        // history capture while MEM load holds execute
        do_reset();
        idle(); src(0, 12, 1, 32'hC); stg(0, 12, 0, 0); stg(2, 9, 1, 32'hDEAD); stg_shift = 1'b1;
        expect_("cap_stall", S_STALL, 1);
        step();
        idle(); src(0, 9, 1, 32'h9);
        expect_("hist_fwd", S_OUT0, 32'hDEAD);
        expect_("hist_stall", S_STALL, 0);
        step();
        idle(); src(0, 9, 1, 32'h9); stg(1, 9, 1, 32'hBEEF);
        expect_("stg_over_hist", S_OUT0, 32'hBEEF);
        step();
        // advance clears on the edge; a simultaneous retirement is not kept
        idle(); src(0, 9, 1, 32'h9); exe_advance = 1'b1; stg(2, 10, 1, 32'h1010); stg_shift = 1'b1;
        expect_("adv_cycle", S_OUT0, 32'hDEAD);
        step();
        idle(); src(0, 9, 1, 32'h9); src(1, 10, 1, 32'hA);
        expect_("adv_clear", S_OUT0, 32'h9);
        expect_("adv_nocap", S_OUT1, 32'hA);
        step();

        // overflow: three retirements into two entries
        do_reset();
        for (int r = 1; r <= 3; r++) begin
            idle(); stg(2, 5'(r), 1, 32'h101 * r); stg_shift = 1'b1;
            if (r == 3) expect_("ovf_before", S_OVF, 0);
            step();
        end
        idle(); src(0, 1, 1, 32'h1); src(1, 2, 1, 32'h2);
        expect_("ovf_set", S_OVF, 1);
        expect_("ovf_drop_r1", S_OUT0, 32'h1);
        expect_("ovf_keep_r2", S_OUT1, 32'h202);
        step();
        idle(); src(0, 3, 1, 32'h3); exe_advance = 1'b1;
        expect_("ovf_keep_r3", S_OUT0, 32'h303);
        step();
        idle();
        expect_("ovf_sticky", S_OVF, 1);
        step();
        // exe_valid=0 clears history too
        idle(); stg(2, 5, 1, 32'h505); stg_shift = 1'b1;
        step();
        idle(); exe_valid = 1'b0; src(0, 5, 1, 32'h5);
        expect_("hist_r5", S_OUT0, 32'h505);
        step();
        idle(); src(0, 5, 1, 32'h5);
        expect_("noexe_clear", S_OUT0, 32'h5);
        step();
        // reset right after a capture
        idle(); stg(2, 6, 1, 32'h606); stg_shift = 1'b1;
        step();
        do_reset();
        idle(); src(0, 6, 1, 32'h6);
        expect_("rst2_hist", S_OUT0, 32'h6);
        expect_("rst2_ovf", S_OVF, 0);
        expect_("rst2_cnt", S_CNT, 0);
        step();

        // stall-only instance: ready stage-1 match stalls; counter saturates
        do_reset();
        for (int c = 0; c < 20; c++) begin
            idle(); src(0, 6, 1, 32'h6); stg(1, 6, 1, 32'h66);
            if (c == 0) begin
                expect_("nf_stall_b", S_STALL_B, 1);
                expect_("nf_fwd_a", S_OUT0, 32'h66);
                expect_("nf_stall_a", S_STALL, 0);
            end
            if (c == 14) expect_("sat_cnt14", S_CNT_B, 14);
            step();
        end
        idle();
        expect_("sat_cnt_b", S_CNT_B, 15);
        expect_("sat_cnt_a", S_CNT, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
